// File: rtl/wm_pkg.sv
// wm_pkg: phase codes and actuator bundle shared by the wash controller and phase timer.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOCK       = 3'd1,
        FILL_WATER = 3'd2,
        HEAT_WATER = 3'd3,
        WASH       = 3'd4,
        RINSE      = 3'd5,
        SPIN       = 3'd6,
        DONE       = 3'd7
    } phase_t;

    typedef struct packed {
        logic water_valve;
        logic heater;
        logic motor;
        logic spin_fast;
        logic drain_pump;
        logic door_lock;
    } act_t;

    function automatic logic is_active(phase_t p);
        return p inside {FILL_WATER, HEAT_WATER, WASH, RINSE, SPIN};
    endfunction

    // A paused phase keeps only the door locked.
    function automatic act_t phase_act(phase_t p, logic paused);
        act_t a;
        a = '0;
        a.door_lock = p != IDLE && p != DONE;
        if (!paused) begin
            a.water_valve = p == FILL_WATER || p == RINSE;
            a.heater      = p == HEAT_WATER;
            a.motor       = p inside {WASH, RINSE, SPIN};
            a.spin_fast   = p == SPIN;
            a.drain_pump  = p == SPIN;
        end
        return a;
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog: counts unpaused cycles within a timed phase and flags when the
// next counted cycle would reach the timeout limit.
module phase_watchdog #(
    parameter int PHASE_TIMEOUT = 255,
    parameter int TO_W          = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            active,
    input  logic            pause,
    input  logic            clear,
    output logic [TO_W-1:0] phase_cnt,
    output logic            timeout
);

    logic tick;

    assign tick    = active && !pause;
    assign timeout = tick && phase_cnt == TO_W'(PHASE_TIMEOUT - 1);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) phase_cnt <= '0;
        else          phase_cnt <= clear ? '0 : tick ? phase_cnt + 1'b1 : phase_cnt;

endmodule

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: sequences lock/fill/heat/wash/rinse/spin with pause, cancel,
// cold-program heat skip, optional extra rinse and a per-phase watchdog.
module wash_cycle_controller
    import wm_pkg::*;
#(
    parameter int LOCK_CYCLES   = 4,
    parameter int PHASE_TIMEOUT = 255,
    parameter int TO_W          = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       door_closed,
    input  logic       cold_prog,
    input  logic       extra_rinse,
    input  logic       pause,
    input  logic       cancel,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       water_valve,
    output logic       heater,
    output logic       motor,
    output logic       spin_fast,
    output logic       drain_pump,
    output logic       door_lock,
    output logic       done,
    output logic       fault
);

    localparam int LC_W = $clog2(LOCK_CYCLES + 1);

    phase_t          cur, nxt;
    act_t            act;
    logic            cold, rinse_left, rinse_pass, fault_nxt;
    logic            paused, flag, adv, timeout;
    logic [LC_W-1:0] lock_cnt;
    logic [TO_W-1:0] phase_cnt;

    phase_watchdog #(.PHASE_TIMEOUT(PHASE_TIMEOUT), .TO_W(TO_W)) u_wd (
        .clock    (clock),
        .reset_n  (reset_n),
        .active   (is_active(cur)),
        .pause    (pause),
        .clear    (nxt != cur),
        .phase_cnt(phase_cnt),
        .timeout  (timeout)
    );

    // Flags are ignored in a phase's first cycle: they may still be left over from the previous phase.
    assign paused = pause && is_active(cur);
    assign flag   = cur == FILL_WATER ? sig_Full
                  : cur == HEAT_WATER ? sig_Temperature
                  : cur inside {WASH, RINSE, SPIN} && sig_Completed;
    assign adv    = flag && phase_cnt != '0 && !paused;

    always_comb begin
        nxt       = cur;
        fault_nxt = fault;
        if (cancel && cur == LOCK)
            nxt = IDLE;
        else if (cancel && cur inside {FILL_WATER, HEAT_WATER, WASH, RINSE})
            nxt = SPIN;
        else if (timeout && !adv) begin
            nxt       = IDLE;
            fault_nxt = 1'b1;
        end else if (!paused)
            case (cur)
                IDLE:       nxt = start && door_closed && !fault ? LOCK : IDLE;
                LOCK:       nxt = !door_closed ? IDLE : lock_cnt == LC_W'(LOCK_CYCLES - 1) ? FILL_WATER : LOCK;
                FILL_WATER: nxt = !adv ? cur : rinse_pass ? RINSE : cold ? WASH : HEAT_WATER;
                HEAT_WATER: nxt = adv ? WASH : cur;
                WASH:       nxt = adv ? RINSE : cur;
                RINSE:      nxt = !adv ? cur : rinse_left ? FILL_WATER : SPIN;
                SPIN:       nxt = adv ? DONE : cur;
                DONE:       nxt = door_closed ? DONE : IDLE;
            endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur        <= IDLE;
            act        <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            cold       <= 1'b0;
            rinse_left <= 1'b0;
            rinse_pass <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            cur      <= nxt;
            fault    <= fault_nxt;
            act      <= phase_act(nxt, pause && is_active(nxt));
            done     <= nxt == DONE;
            lock_cnt <= cur == LOCK && nxt == LOCK ? lock_cnt + 1'b1 : '0;
            if (cur == IDLE && nxt == LOCK) begin
                cold       <= cold_prog;
                rinse_left <= extra_rinse;
                rinse_pass <= 1'b0;
            end else if (cur == RINSE && nxt == FILL_WATER) begin
                rinse_left <= 1'b0;
                rinse_pass <= 1'b1;
            end
        end
    end

    assign state = cur;
    assign {water_valve, heater, motor, spin_fast, drain_pump, door_lock} = act;

endmodule

// File: doc/wash_cycle_controller.md
# wash_cycle_controller

Top-level sequencer for the washing-machine controller. It steps the machine through lock, fill, heat, wash, rinse and spin, and drives the 3-bit phase code consumed by the phase timer. It advances on the timer's `sig_Full`, `sig_Temperature` and `sig_Completed` flags and drives the actuator enables. It also adds pause, cancel, a cold-program heat skip, an optional extra rinse and a per-phase watchdog.

## Interface
- `LOCK_CYCLES`, default 4: cycles the door must stay closed in LOCK before filling starts.
- `PHASE_TIMEOUT`, default 255: watchdog limit, in active cycles per phase.
- `TO_W`, default 8: watchdog counter width. Must satisfy `PHASE_TIMEOUT` ≤ 2^`TO_W`−1.
- `clock` in 1: the single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; begins a cycle from IDLE.
- `door_closed` in 1: door sensor.
- `cold_prog` in 1: sampled on start; 1 skips HEAT.
- `extra_rinse` in 1: sampled on start; 1 runs a second fill/rinse pass.
- `pause` in 1: level; freezes the sequence.
- `cancel` in 1: pulse; aborts the cycle to drain/spin.
- `sig_Full`, `sig_Temperature`, `sig_Completed` in 1 each: timer flags.
- `state` out 3: phase code driven to the timer.
- `water_valve`, `heater`, `motor`, `spin_fast`, `drain_pump`, `door_lock` out 1 each: actuator enables.
- `done` out 1: cycle finished.
- `fault` out 1: sticky watchdog fault flag.

## Operation
- Phase codes: IDLE=0, LOCK=1, FILL=2, HEAT=3, WASH=4, RINSE=5, SPIN=6, DONE=7. Codes 2–6 are fixed by the timer.
- IDLE
  - If `start`, `door_closed` and not `fault`: go to LOCK. On that edge, latch `cold_prog` and `extra_rinse`, and load `rinse_left` = `extra_rinse`.
- LOCK
  - `door_closed`=0 at any point: return to IDLE.
  - After `LOCK_CYCLES` consecutive closed cycles: go to FILL.
- FILL
  - On a qualified `sig_Full`: go to RINSE if `rinse_pass`=1; otherwise go to WASH if cold, else HEAT.
- HEAT: on a qualified `sig_Temperature`, go to WASH.
- WASH: on a qualified `sig_Completed`, go to RINSE.
- RINSE
  - On a qualified `sig_Completed` with `rinse_left`=1: clear `rinse_left`, set `rinse_pass`, go to FILL.
  - On a qualified `sig_Completed` otherwise: go to SPIN.
- SPIN: on a qualified `sig_Completed`, go to DONE.
- DONE: `done`=1 and the door is unlocked. Go to IDLE when `door_closed`=0.
- Qualification: a timer flag counts only when `phase_cnt` ≥ 1, i.e. never in the first cycle of a phase, because timer flags may be stale from the previous phase.
- Actuators, driven as a function of phase:
  - FILL: `water_valve`.
  - HEAT: `heater`.
  - WASH: `motor`.
  - RINSE: `water_valve` and `motor`.
  - SPIN: `motor`, `spin_fast` and `drain_pump`.
  - `door_lock`=1 in phases 1–6.
- Pause, in phases 2–6:
  - Phase holds and all actuators are 0 except `door_lock`.
  - Timer flags are ignored and the watchdog is frozen.
- Cancel, in phases 1–5:
  - Next phase is SPIN, even while paused.
  - Cancel in LOCK goes to IDLE instead.
  - Cancel in SPIN or DONE is ignored.
- Watchdog, in phases 2–6:
  - `phase_cnt` counts unpaused cycles and clears on every phase change.
  - If it reaches `PHASE_TIMEOUT` with no qualified flag: `fault`←1, go to IDLE, all outputs 0.
  - `fault` clears only on reset.
- Simultaneous events, in priority order: reset > cancel > watchdog > pause > flag advance.

## Timing
- Reset: `state`=IDLE, all actuators 0, `done`=0, `fault`=0; all counters and latches cleared.
- Outputs are registered and change on the same edge as `state`. There is no combinational input-to-output path.
- A qualified flag sampled at edge N gives the new `state` and actuators after edge N.
- LOCK→FILL happens on the edge that completes `LOCK_CYCLES` closed cycles. With the default, the minimum is 4 cycles in LOCK.
- Reset asserted mid-phase: everything returns to IDLE immediately and asynchronously, with actuators off.

## Structure
- Shared package `wm_pkg`:
  - phase-code constants: IDLE, LOCK, FILL_WATER, HEAT_WATER, WASH, RINSE, SPIN, DONE;
  - the actuator-bundle typedef.
  - The timer is to import the same constants.
- One sub-module, `phase_watchdog`, holding `phase_cnt`, clear-on-change, freeze-on-pause and the timeout compare.
- The controller holds the FSM, the option latches and the output decode.

## Test plan
- Hot cycle with `cold_prog`=0, `extra_rinse`=0 and flags pulsed 3 cycles into each phase:
  - phases are 0,1,2,3,4,5,6,7;
  - with door opened in DONE, phase returns to 0, and `done` was high only in DONE.
- Cold cycle with an extra rinse (`cold_prog`=1, `extra_rinse`=1):
  - sequence is 2→4→5→2→5→6, with HEAT never entered and `heater` never 1.
- `sig_Full` held high from the moment FILL is entered:
  - no advance in FILL's first cycle; advance on the second cycle.
- `pause` raised for 20 cycles in WASH with `sig_Completed` pulsed during the pause:
  - phase stays 4 with `motor`=0 and `door_lock`=1;
  - the watchdog count is unchanged across the pause.
- `cancel` pulsed in HEAT:
  - next phase is SPIN, with `drain_pump`, `motor` and `spin_fast` at 1;
  - `sig_Completed` then gives DONE.
- No `sig_Full` for 255 cycles in FILL:
  - `fault`=1, phase 0, all actuators 0;
  - a later `start` is ignored until `reset_n` is pulsed low.
